// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART transmitter: FSM state encoding,
// default bit timing and the parity helper.
// Latency: n/a (package). Backpressure: n/a (package).
// Optional feature macro: UART_HOST_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

   // 100 MHz core clock / 115200 baud.
   localparam int DEFAULT_BAUD_DIV = 868;

   // Baud counter width covers the full legal BAUD_DIV range (2..65535).
   localparam int BAUD_CNT_W = 16;

`ifdef UART_HOST_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;
`else
   // 8N1 framing: there is no parity state at all in this build.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } tx_state_t;
`endif

   // Even parity: the parity bit makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART shifter: registered storage, full/empty, count.
// Latency: a pushed byte is visible at head the cycle after the accepting edge.
// Backpressure: push is ignored while full; full does not depend on a same-cycle pop.
// Ports: clk/reset (sync, active-high), push/push_data, pop, head (current
// oldest entry), full, empty, count (entries held, 0..DEPTH).
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: FIFO-buffered bytes serialised LSB first, 8N1 or 8E1.
// Latency: tx falls 2 cycles after the first accepting edge; frames back to back.
// Backpressure: in_ready = FIFO not full; bytes offered while full are ignored.
// Ports: clk, reset (sync, active-high), in_valid/in_data/in_ready (byte input),
// tx (registered serial line, idle high), busy, fifo_count (bytes queued).
// Build option: define UART_HOST_TX_PARITY_EN for an even-parity bit (8E1).
module uart_host_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

   tx_state_t             state;
   logic [BAUD_CNT_W-1:0] baud_cnt;
   logic [2:0]            bit_idx;
   logic [7:0]            shift_reg;
   logic                  line_active;
   logic                  bit_end;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [7:0]            fifo_head;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign in_ready = !fifo_full;
   assign bit_end  = (baud_cnt == '0);

   // A byte leaves the FIFO either when idle or exactly at the end of a stop
   // bit, which is what keeps consecutive frames gap-free.
   assign fifo_pop = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && bit_end));

   // tx is registered from the current state, so the line trails the state by
   // one cycle; every state lasts BAUD_DIV cycles, so every bit on the line
   // does too. line_active covers that trailing cycle so busy stays high until
   // the last stop-bit cycle has actually been driven.
   assign busy = (state != IDLE) || (fifo_count != '0) || line_active;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tx          <= 1'b1;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         line_active <= 1'b0;
      end else begin
         line_active <= (state != IDLE);
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (fifo_pop) begin
                  shift_reg <= fifo_head;
                  baud_cnt  <= BAUD_RELOAD;
                  state     <= START;
               end
            end

            START: begin
               tx <= 1'b0;
               if (bit_end) begin
                  baud_cnt <= BAUD_RELOAD;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

            DATA: begin
               tx <= shift_reg[bit_idx];
               if (bit_end) begin
                  baud_cnt <= BAUD_RELOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_HOST_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

`ifdef UART_HOST_TX_PARITY_EN
            PARITY: begin
               tx <= even_parity(shift_reg);
               if (bit_end) begin
                  baud_cnt <= BAUD_RELOAD;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif

            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= BAUD_RELOAD;
                  if (fifo_pop) begin
                     shift_reg <= fifo_head;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_tx.sv
// Testbench for uart_host_tx: a fast instance (BAUD_DIV=4, FIFO_DEPTH=4) and a
// full-rate instance (BAUD_DIV=868) whose line feeds a UART receiver model.
// Expected frames are queued as stimulus is issued; line monitors decode frames.
module tb_uart_host_tx;

   localparam int BD   = 4;
   localparam int SBD  = 868;
`ifdef UART_HOST_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, s_in_valid;
   logic [7:0] in_data, s_in_data;
   logic       in_ready, s_in_ready;
   logic       tx, s_tx;
   logic       busy, s_busy;
   logic [2:0] fifo_count, s_fifo_count;

   int cyc = 0;
   int rst_cnt = 0;
   int n_chk = 0;
   int n_pass = 0;
   int max_cnt = 0;
   int last_start [2];

   typedef struct {
      logic [7:0] data;
      int         start;   // absolute start-bit cycle, -1 = don't care
      int         gap;     // start-to-start distance from previous frame, -1 = don't care
      int         par;     // expected parity bit, -1 = don't care
   } exp_t;

   exp_t exp_q [$];
   exp_t exp_s_q [$];

   uart_host_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   uart_host_tx #(.BAUD_DIV(SBD), .FIFO_DEPTH(4)) u_dut_slow (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (s_in_valid),
      .in_data    (s_in_data),
      .in_ready   (s_in_ready),
      .tx         (s_tx),
      .busy       (s_busy),
      .fifo_count (s_fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) rst_cnt <= rst_cnt + 1;
   end

   always @(negedge clk) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic line(input bit slow);
      return slow ? s_tx : tx;
   endfunction

   function automatic logic rdy(input bit slow);
      return slow ? s_in_ready : in_ready;
   endfunction

   task automatic expect_frame(input bit slow, input logic [7:0] d, input int start,
                               input int gap, input int par);
      exp_t e;
      e.data = d; e.start = start; e.gap = gap; e.par = par;
      if (slow) exp_s_q.push_back(e);
      else      exp_q.push_back(e);
   endtask

   // Called just after a falling edge; holds the byte until accepted (bounded).
   // acc returns the cycle number of the accepting rising edge.
   task automatic push(input bit slow, input logic [7:0] d, output int acc);
      int waited = 0;
      if (slow) begin s_in_valid = 1'b1; s_in_data = d; end
      else      begin in_valid = 1'b1;   in_data = d;   end
      while (rdy(slow) !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) begin
         n_chk++;
         $display("FAIL push_timeout: in_ready stayed %b, expected 1", rdy(slow));
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (slow) begin s_in_valid = 1'b0; s_in_data = 8'h00; end
      else      begin in_valid = 1'b0;   in_data = 8'h00;   end
      @(negedge clk);
   endtask

   task automatic score(input bit slow, input int s, input logic [7:0] d,
                        input logic st, input logic p, input logic stp);
      exp_t  e;
      string tag = slow ? "slow" : "fast";
      if ((slow && exp_s_q.size() == 0) || (!slow && exp_q.size() == 0)) begin
         n_chk++;
         $display("FAIL %s_unexpected_frame: got byte %02h expected no frame", tag, d);
         return;
      end
      e = slow ? exp_s_q.pop_front() : exp_q.pop_front();
      chk({tag, "_data"}, d, e.data);
      chk({tag, "_start_bit"}, st, 1'b0);
      chk({tag, "_stop_bit"}, stp, 1'b1);
      if (e.start >= 0) chk({tag, "_start_cycle"}, s, e.start);
      if (e.gap >= 0)   chk({tag, "_frame_gap"}, s - last_start[slow], e.gap);
`ifdef UART_HOST_TX_PARITY_EN
      if (e.par >= 0)   chk({tag, "_parity"}, p, e.par[0]);
`else
      if (p !== 1'b0) $display("note: unexpected parity sample");
`endif
      last_start[slow] = s;
   endtask

   // Receiver model: detect the start bit, sample every bit at its centre.
   task automatic rx_monitor(input bit slow);
      int         bd;
      int         s, r0;
      logic [7:0] d;
      logic       st, p, stp;
      bd = slow ? SBD : BD;
      forever begin
         @(negedge clk);
         if (reset || line(slow) !== 1'b0) continue;
         s  = cyc;
         r0 = rst_cnt;
         repeat (bd / 2) @(negedge clk);
         st = line(slow);
         for (int i = 0; i < 8; i++) begin
            repeat (bd) @(negedge clk);
            d[i] = line(slow);
         end
`ifdef UART_HOST_TX_PARITY_EN
         repeat (bd) @(negedge clk);
         p = line(slow);
`else
         p = 1'b0;
`endif
         repeat (bd) @(negedge clk);
         stp = line(slow);
         if (rst_cnt != r0) continue;   // frame cut short by reset
         score(slow, s, d, st, p, stp);
      end
   endtask

   initial rx_monitor(1'b0);
   initial rx_monitor(1'b1);

   task automatic wait_idle(input bit slow, input int budget);
      int t = 0;
      while (((slow ? s_busy : busy) !== 1'b0 ||
              (slow ? exp_s_q.size() : exp_q.size()) != 0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(slow ? "slow_idle" : "fast_idle", slow ? s_busy : busy, 1'b0);
   endtask

   initial begin
      #800000;
      $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int a, a0, t, dummy;
      bit seen_low;

      // Reset, with in_valid asserted throughout: nothing may be queued.
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      s_in_valid = 1'b0; s_in_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      chk("rst_tx", tx, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fifo_count", fifo_count, 3'd0);
      chk("rst_slow_tx", s_tx, 1'b1);
      chk("rst_slow_count", s_fifo_count, 3'd0);

      // Single byte 0xA5: start bit two cycles after the accepting edge.
      push(1'b0, 8'hA5, a);
      expect_frame(1'b0, 8'hA5, a + 2, -1, 0);
      chk("busy_after_push", busy, 1'b1);
      t = 0;
      while (busy !== 1'b0 && t < 500) begin @(negedge clk); t++; end
      chk("busy_fall_cycle", cyc, a + 2 + FB * BD);
      wait_idle(1'b0, 200);

      // Fill while the shifter is busy: 0x01..0x04 fill the FIFO, 0x05 waits.
      max_cnt = 0;
      push(1'b0, 8'h5A, a0);
      expect_frame(1'b0, 8'h5A, a0 + 2, -1, -1);
      for (int i = 1; i <= 4; i++) begin
         push(1'b0, 8'(i), dummy);
         expect_frame(1'b0, 8'(i), -1, FB * BD, -1);
      end
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_count", fifo_count, 3'd4);
      push(1'b0, 8'h05, dummy);
      expect_frame(1'b0, 8'h05, -1, FB * BD, -1);
      wait_idle(1'b0, 600);
      chk("max_fifo_count", max_cnt, 4);

      // Simultaneous push and pop at fifo_count=2.
      push(1'b0, 8'h11, a);
      expect_frame(1'b0, 8'h11, a + 2, -1, -1);
      push(1'b0, 8'h22, dummy);
      expect_frame(1'b0, 8'h22, -1, FB * BD, -1);
      push(1'b0, 8'h33, dummy);
      expect_frame(1'b0, 8'h33, -1, FB * BD, -1);
      while (cyc < a + FB * BD) @(negedge clk);
      chk("pushpop_count_before", fifo_count, 3'd2);
      in_valid = 1'b1; in_data = 8'h44;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      chk("pushpop_count_after", fifo_count, 3'd2);
      expect_frame(1'b0, 8'h44, -1, FB * BD, -1);
      wait_idle(1'b0, 600);

      // Reset during data bit 3 of 0x3C with two bytes queued behind it.
      push(1'b0, 8'h3C, a);
      push(1'b0, 8'h5B, dummy);
      push(1'b0, 8'h6D, dummy);
      chk("abort_queued", fifo_count, 3'd2);
      while (cyc < a + 19) @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      @(posedge clk);
      @(negedge clk);
      chk("abort_tx", tx, 1'b1);
      chk("abort_count", fifo_count, 3'd0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      seen_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
      end
      chk("abort_no_more_frames", seen_low, 1'b0);
      chk("abort_count_later", fifo_count, 3'd0);

`ifdef UART_HOST_TX_PARITY_EN
      // Even parity: 0x07 has three ones -> 1, 0x03 has two ones -> 0.
      push(1'b0, 8'h07, a);
      expect_frame(1'b0, 8'h07, a + 2, -1, 1);
      push(1'b0, 8'h03, dummy);
      expect_frame(1'b0, 8'h03, -1, 44, 0);
      wait_idle(1'b0, 300);
`endif

      // Full-rate instance into the receiver model.
      push(1'b1, 8'h00, a);
      expect_frame(1'b1, 8'h00, a + 2, -1, -1);
      push(1'b1, 8'hFF, dummy);
      expect_frame(1'b1, 8'hFF, -1, FB * SBD, -1);
      push(1'b1, 8'h55, dummy);
      expect_frame(1'b1, 8'h55, -1, FB * SBD, -1);
      wait_idle(1'b1, 3 * FB * SBD + 200);

      chk("fast_queue_drained", exp_q.size(), 0);
      chk("slow_queue_drained", exp_s_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_host_tx.md
UART_HOST_TX -- requirements
Module: uart_host_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  byte offered by producer.
REQ-006 SHALL have port in_data  input  8  byte to transmit, LSB sent first.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, drives DUT UART rx, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-011 SHALL accept a byte on any rising edge where in_valid && in_ready; in_ready SHALL equal !full, independent of same-cycle pop.
REQ-012 SHALL ignore in_valid while full; in_data need not be held stable when in_ready=0.
REQ-013 SHALL keep fifo_count unchanged on simultaneous push and pop; SHALL never over- or underflow; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE with FIFO non-empty, pop head into shift register and enter START on the same edge; tx=0 from the next cycle.
REQ-016 SHALL hold each bit for exactly BAUD_DIV cycles using a baud counter reloaded at every state/bit change.
REQ-017 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit index; after bit 7 go to PARITY (if enabled) else STOP.
REQ-018 SHALL drive tx=1 for one bit time in STOP; at STOP end, if FIFO non-empty, pop and go directly to START, else IDLE.
REQ-019 SHALL space back-to-back start bits exactly 10*BAUD_DIV cycles apart (11*BAUD_DIV with parity).
REQ-020 SHALL drive tx from a register (glitch-free); tx=1 in IDLE.
REQ-021 SHALL assert busy whenever state!=IDLE or fifo_count!=0; latency from first accepting edge to tx falling: 2 cycles.

Reset
REQ-022 SHALL on reset: state=IDLE, tx=1, fifo_count=0, in_ready=1, busy=0, counters and pointers zero.
REQ-023 SHALL, if reset asserts mid-frame, abort the frame, drive tx=1 from the next cycle and discard all queued bytes.
REQ-024 SHALL ignore in_valid during reset cycles.

Configuration
REQ-025 SHALL, with UART_HOST_TX_PARITY_EN defined, insert an even-parity bit (XOR of 8 data bits) in state PARITY between bit 7 and stop.
REQ-026 SHALL, without UART_HOST_TX_PARITY_EN, omit state PARITY entirely (8N1 framing).

Structure
REQ-027 SHALL place FSM state enum, default BAUD_DIV and parity helper function in shared package uart_pkg.
REQ-028 SHALL implement the FIFO as sub-module uart_tx_fifo (registers, full/empty, count); FSM and baud counter in uart_host_tx.

Verification (BAUD_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-029 SHALL check single byte 0xA5 pushed at cycle 0 -> tx low from cycle 2 for 4 cycles, bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, busy falls after stop.
REQ-030 SHALL check 5 pushes of 0x01..0x05 back-to-back -> 5th push refused while full (in_ready=0), fifo_count never >4, frames contiguous 40 cycles apart.
REQ-031 SHALL check push and pop on same edge at fifo_count=2 -> fifo_count stays 2, byte order preserved.
REQ-032 SHALL check reset asserted during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 next cycle, fifo_count=0, no further start bits.
REQ-033 SHALL check with UART_HOST_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame length 44 cycles; byte 0x03 -> parity bit 0.
REQ-034 SHALL check BAUD_DIV=868 loopback into soc UART rx -> SoC-received byte equals sent byte for 0x00, 0xFF, 0x55.
